// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch controller.
// Fetch FSM states, queue depth and queue entry layout.
package fetch_pkg;

  localparam int FQ_DEPTH = 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched instructions with flush.
// Storage is cleared on reset so the head reads as zero.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [FQ_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != 2'(FQ_DEPTH));
  assign do_pop  = pop && (count != 2'd0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request,
// redirect handling and a 2-entry queue towards decode.
module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc
);

  fetch_state_t state;
  fetch_state_t state_n;
  logic [31:0]  pc_tag;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_data;
  logic         accept;
  logic         push;
  logic         pop;

  assign imem_req_valid = !reset && (state == FETCH)
                       && (count < 2'(FQ_DEPTH))
                       && !redirect_valid;
  assign accept    = imem_req_valid && imem_req_ready;
  assign imem_addr = pc;

  assign push = (state == WAIT) && imem_rvalid
             && !redirect_valid;
  assign pop  = dec_valid && dec_ready;

  // Tag holds the fall-through address; entries record the
  // instruction's own PC.
  assign push_data = '{pc: pc_tag - 32'd4, instr: imem_rdata};

  assign dec_valid = (count != 2'd0);
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;

  always_comb begin
    pc_next = pc;
    if (!reset) begin
      if (redirect_valid) begin
        pc_next = {redirect_target[31:2], 2'b00};
      end else if (accept) begin
        pc_next = pc + 32'd4;
      end
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH: if (accept) state_n = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          state_n = FETCH;
        end else if (redirect_valid) begin
          state_n = DRAIN;
        end
      end
      DRAIN: if (imem_rvalid) state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc_tag <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        pc_tag <= pc + 32'd4;
      end
    end
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table plus scoreboarded
// sequences against a small memory and decode model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  logic        manual;
  logic [31:0] pc_man;
  logic [31:0] pc_reg;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_pcn;
  } vec_t;

  vec_t vecs [8];

  fetch_state_t m_state;
  fetch_entry_t sb [$];
  logic         pend;
  int           pend_wait;
  logic [31:0]  pend_addr;
  int           lat;
  logic         mem_ready;
  logic         dready;
  logic         rv_next;
  logic [31:0]  tgt_next;
  int           cyc;
  logic [31:0]  acc_addr [$];
  int           acc_cyc [$];
  logic [31:0]  pop_pc [$];
  logic [31:0]  pop_instr [$];

  fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register outside the controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= '0;
    else       pc_reg <= pc_next;
  end

  assign pc = manual ? pc_man : pc_reg;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return {16'hc0de, a[15:0]};
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait bound expired", name);
  endtask

  task automatic model_reset();
    sb.delete();
    pend      = 1'b0;
    pend_wait = 0;
    pend_addr = '0;
    m_state   = FETCH;
    rv_next   = 1'b0;
    tgt_next  = '0;
    cyc       = 0;
    acc_addr.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_instr.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2;
    reset          = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    model_reset();
  endtask

  task automatic reset_seq();
    @(negedge clk);
    reset = 1'b1;
    release_reset();
  endtask

  // One clock cycle: drive at negedge, compare 1ns later.
  task automatic cycle();
    logic         rv;
    logic         fire;
    logic         exp_req;
    logic         acc;
    logic [31:0]  exp_pcn;
    fetch_entry_t e;
    @(negedge clk);
    rv      = rv_next;
    rv_next = 1'b0;
    fire    = pend && (pend_wait == 0);
    imem_rvalid     = fire;
    imem_rdata      = fire ? mem_word(pend_addr) : 32'h0;
    redirect_valid  = rv;
    redirect_target = tgt_next;
    imem_req_ready  = mem_ready;
    dec_ready       = dready;
    #1;
    assert (!(fire && m_state == FETCH))
      else $error("memory model answered in FETCH");
    exp_req = (m_state == FETCH) && (sb.size() < 2) && !rv;
    acc     = exp_req && mem_ready;
    if (rv)       exp_pcn = {tgt_next[31:2], 2'b00};
    else if (acc) exp_pcn = pc + 32'd4;
    else          exp_pcn = pc;
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    check("dec_valid", 32'(dec_valid), 32'(sb.size() != 0));
    check("pc_next", pc_next, exp_pcn);
    if (imem_req_valid) check("imem_addr", imem_addr, pc);
    if (sb.size() != 0 && dready && !rv) begin
      e = sb.pop_front();
      check("dec_pc", dec_pc, e.pc);
      check("dec_instr", dec_instr, e.instr);
      pop_pc.push_back(dec_pc);
      pop_instr.push_back(dec_instr);
    end
    if (rv) sb.delete();
    if (fire) begin
      pend = 1'b0;
      if (m_state == WAIT && !rv)
        sb.push_back('{pc: pend_addr, instr: mem_word(pend_addr)});
    end else if (pend) begin
      pend_wait--;
    end
    if (acc) begin
      pend      = 1'b1;
      pend_wait = lat - 1;
      pend_addr = pc;
      acc_addr.push_back(pc);
      acc_cyc.push_back(cyc);
    end
    case (m_state)
      FETCH: if (acc) m_state = WAIT;
      WAIT:  if (fire) m_state = FETCH;
             else if (rv) m_state = DRAIN;
      DRAIN: if (fire) m_state = FETCH;
      default: m_state = FETCH;
    endcase
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   n0;
    checks          = 0;
    failures        = 0;
    manual          = 1'b1;
    pc_man          = '0;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    imem_req_ready  = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    dec_ready       = 1'b0;
    mem_ready       = 1'b1;
    dready          = 1'b1;
    lat             = 1;
    model_reset();

    vecs[0] = '{1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h40};
    vecs[1] = '{1'b1, 32'h44, 1'b1, 32'h80, 1'b1, 1'b0, 32'h44};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 32'h10, 1'b1, 32'h203, 1'b0, 1'b0, 32'h200};
    vecs[4] = '{1'b0, 32'h20, 1'b1, 32'hffff_ffff, 1'b0, 1'b0,
                32'hffff_fffc};
    vecs[5] = '{1'b0, 32'hffff_fffc, 1'b0, 32'h0, 1'b0, 1'b1,
                32'hffff_fffc};
    vecs[6] = '{1'b0, 32'hffff_fffc, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h8, 1'b1, 32'h100, 1'b1, 1'b0, 32'h100};

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset           = vecs[i].rst;
      pc_man          = vecs[i].pc;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      imem_req_ready  = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d_req", i), 32'(imem_req_valid),
            32'(vecs[i].exp_req));
      check($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].exp_pcn);
      if (vecs[i].exp_req)
        check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].pc);
      if (vecs[i].rst) begin
        check($sformatf("vec%0d_dvalid", i), 32'(dec_valid), 32'h0);
        check($sformatf("vec%0d_dinstr", i), dec_instr, 32'h0);
        check($sformatf("vec%0d_dpc", i), dec_pc, 32'h0);
      end
      #1;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
    end
    manual = 1'b0;

    // zero-wait streaming
    reset_seq();
    mem_ready = 1'b1; dready = 1'b1; lat = 1;
    repeat (12) cycle();
    if (acc_addr.size() < 3 || pop_pc.size() < 3) begin
      expire("stream_count");
    end else begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("stream_addr%0d", i), acc_addr[i], 32'(4 * i));
        check($sformatf("stream_dpc%0d", i), pop_pc[i], 32'(4 * i));
        if (i > 0)
          check($sformatf("stream_gap%0d", i),
                32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
      end
    end

    // decode backpressure fills the queue
    reset_seq();
    dready = 1'b0; lat = 1;
    repeat (8) cycle();
    check("bp_req_valid", 32'(imem_req_valid), 32'h0);
    check("bp_dec_valid", 32'(dec_valid), 32'h1);
    check("bp_head_hold", dec_instr, 32'h0000_0013);
    check("bp_issued", 32'(acc_addr.size()), 32'd2);
    dready = 1'b1;
    repeat (6) cycle();
    if (pop_instr.size() < 2) begin
      expire("bp_pops");
    end else begin
      check("bp_word0", pop_instr[0], 32'h0000_0013);
      check("bp_word1", pop_instr[1], 32'h0010_0093);
    end
    check("bp_resume", 32'(acc_addr.size() > 2), 32'h1);

    // redirect while waiting on 0x8
    reset_seq();
    dready = 1'b1; lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      found = (m_state == WAIT) && pend && (pend_addr == 32'h8)
           && (pend_wait > 0);
    end
    if (!found) expire("rd_reach_wait");
    rv_next = 1'b1; tgt_next = 32'h100;
    cycle();
    cycle();
    check("rd_drain_noreq", 32'(imem_req_valid), 32'h0);
    check("rd_queue_empty", 32'(dec_valid), 32'h0);
    n0 = acc_addr.size();
    for (int i = 0; i < 20 && acc_addr.size() == n0; i++) cycle();
    if (acc_addr.size() == n0) expire("rd_next_req");
    else check("rd_next_addr", acc_addr[n0], 32'h100);

    // redirect in FETCH while decode is consuming
    reset_seq();
    dready = 1'b0; lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = (m_state == FETCH) && (sb.size() >= 1);
    end
    if (!found) expire("rf_reach_fetch");
    dready = 1'b1;
    rv_next = 1'b1; tgt_next = 32'h203;
    cycle();
    check("rf_pc_next", pc_next, 32'h200);
    check("rf_no_pop", 32'(pop_pc.size()), 32'h0);
    cycle();
    check("rf_flushed", 32'(dec_valid), 32'h0);
    check("rf_addr", imem_addr, 32'h200);

    // redirect and response in the same WAIT cycle
    reset_seq();
    dready = 1'b1; lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = (m_state == WAIT) && pend && (pend_wait == 0)
           && (pend_addr == 32'h4);
    end
    if (!found) expire("rr_reach_wait");
    rv_next = 1'b1; tgt_next = 32'h300;
    cycle();
    cycle();
    check("rr_req", 32'(imem_req_valid), 32'h1);
    check("rr_addr", imem_addr, 32'h300);
    check("rr_no_push", 32'(dec_valid), 32'h0);

    // asynchronous reset while waiting with one entry queued
    reset_seq();
    dready = 1'b0; lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = (m_state == WAIT) && (sb.size() == 1);
    end
    if (!found) expire("ar_reach_wait");
    check("ar_pre_valid", 32'(dec_valid), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("ar_dec_valid", 32'(dec_valid), 32'h0);
    check("ar_req_valid", 32'(imem_req_valid), 32'h0);
    check("ar_dec_instr", dec_instr, 32'h0);
    check("ar_dec_pc", dec_pc, 32'h0);
    check("ar_pc_next", pc_next, pc);
    release_reset();
    dready = 1'b1; lat = 1;
    for (int i = 0; i < 5 && acc_addr.size() == 0; i++) cycle();
    if (acc_addr.size() == 0) begin
      expire("ar_restart");
    end else begin
      check("ar_restart_addr", acc_addr[0], 32'h0);
      check("ar_restart_cycle", 32'(acc_cyc[0]), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
